// File: rtl/ald_pkg.sv
// Shared definitions for the ALD cycle sequencer: state/phase encodings,
// recipe register addresses and recipe reset defaults.
package ald_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PREP    = 4'd1,
    ST_PULSE_P = 4'd2,
    ST_WAIT_P  = 4'd3,
    ST_VAC_P   = 4'd4,
    ST_PULSE_W = 4'd5,
    ST_WAIT_W  = 4'd6,
    ST_VAC_W   = 4'd7,
    ST_DONE    = 4'd8,
    ST_FAULT   = 4'd9
  } state_t;

  localparam logic [2:0] ADDR_PULSE_P = 3'd0;
  localparam logic [2:0] ADDR_WAIT_P  = 3'd1;
  localparam logic [2:0] ADDR_VAC_P   = 3'd2;
  localparam logic [2:0] ADDR_PULSE_W = 3'd3;
  localparam logic [2:0] ADDR_WAIT_W  = 3'd4;
  localparam logic [2:0] ADDR_VAC_W   = 3'd5;
  localparam logic [2:0] ADDR_TARGET  = 3'd6;
  localparam logic [2:0] ADDR_RSVD    = 3'd7;

  localparam int unsigned DEF_PULSE_P = 2000;
  localparam int unsigned DEF_WAIT_P  = 3000;
  localparam int unsigned DEF_VAC_P   = 4000;
  localparam int unsigned DEF_PULSE_W = 6000;
  localparam int unsigned DEF_WAIT_W  = 7000;
  localparam int unsigned DEF_VAC_W   = 8000;
  localparam int unsigned DEF_TARGET  = 9;

endpackage

// File: rtl/ald_phase_timer.sv
// Tick accumulator for one timed phase; expire is high in the clk the phase
// should end. A zero duration expires immediately without waiting for a tick.
module ald_phase_timer #(
  parameter int DUR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic [DUR_W-1:0] dur,
  output logic             expire
);

  logic [DUR_W-1:0] acc;
  logic [DUR_W-1:0] acc_inc;

  assign acc_inc = acc + DUR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (tick) begin
      acc <= acc_inc;
    end
  end

  assign expire = (dur == '0) || (tick && (acc_inc == dur));

endmodule

// File: rtl/ald_cycle_sequencer.sv
// ALD recipe sequencer: N cycles of six timed valve phases.
// Optional pressure interlock enabled by defining ALD_INTERLOCK_EN.
module ald_cycle_sequencer
  import ald_pkg::*;
#(
  parameter int DUR_W = 32,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             temp_ok,
  input  logic             pressure_ok,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [DUR_W-1:0] cfg_wdata,
  output logic             sv_prec,
  output logic             sv_water,
  output logic             vv1,
  output logic             vv2,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [3:0]       phase,
  output logic [CYC_W-1:0] cycle_count
);

  state_t           state;
  state_t           state_next;
  logic [CYC_W-1:0] cnt_next;
  logic [CYC_W-1:0] cnt_inc;
  logic [DUR_W-1:0] dur_q [6];
  logic [CYC_W-1:0] target_q;
  logic [DUR_W-1:0] cur_dur;
  logic             start_q;
  logic             start_edge;
  logic             expire;
  logic             timed;
  logic             timer_clear;

  // Recipe registers are writable only while the sequencer is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dur_q[0] <= DUR_W'(DEF_PULSE_P);
      dur_q[1] <= DUR_W'(DEF_WAIT_P);
      dur_q[2] <= DUR_W'(DEF_VAC_P);
      dur_q[3] <= DUR_W'(DEF_PULSE_W);
      dur_q[4] <= DUR_W'(DEF_WAIT_W);
      dur_q[5] <= DUR_W'(DEF_VAC_W);
      target_q <= CYC_W'(DEF_TARGET);
    end else if (cfg_we && !busy) begin
      case (cfg_addr)
        ADDR_PULSE_P: dur_q[0] <= cfg_wdata;
        ADDR_WAIT_P:  dur_q[1] <= cfg_wdata;
        ADDR_VAC_P:   dur_q[2] <= cfg_wdata;
        ADDR_PULSE_W: dur_q[3] <= cfg_wdata;
        ADDR_WAIT_W:  dur_q[4] <= cfg_wdata;
        ADDR_VAC_W:   dur_q[5] <= cfg_wdata;
        ADDR_TARGET:  target_q <= cfg_wdata[CYC_W-1:0];
        default: ;
      endcase
    end
  end

  assign start_edge = start && !start_q;
  assign timed = state inside {ST_PULSE_P, ST_WAIT_P, ST_VAC_P,
                               ST_PULSE_W, ST_WAIT_W, ST_VAC_W};
  assign timer_clear = (state_next != state) || !timed;
  assign cnt_inc = (cycle_count == '1) ? cycle_count : cycle_count + CYC_W'(1);

  always_comb begin
    cur_dur = '0;
    case (state)
      ST_PULSE_P: cur_dur = dur_q[0];
      ST_WAIT_P:  cur_dur = dur_q[1];
      ST_VAC_P:   cur_dur = dur_q[2];
      ST_PULSE_W: cur_dur = dur_q[3];
      ST_WAIT_W:  cur_dur = dur_q[4];
      ST_VAC_W:   cur_dur = dur_q[5];
      default:    cur_dur = '0;
    endcase
  end

  ald_phase_timer #(.DUR_W(DUR_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .tick   (tick),
    .dur    (cur_dur),
    .expire (expire)
  );

  // Stop overrides everything else, including start and phase completion.
  always_comb begin
    state_next = state;
    cnt_next   = cycle_count;
    if (stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state_next = ST_PREP;
            cnt_next   = '0;
          end
        end
        ST_PREP: begin
          if (temp_ok && tick) state_next = (target_q == '0) ? ST_DONE : ST_PULSE_P;
        end
        ST_PULSE_P: if (expire) state_next = ST_WAIT_P;
        ST_WAIT_P:  if (expire) state_next = ST_VAC_P;
        ST_VAC_P:   if (expire) state_next = ST_PULSE_W;
        ST_PULSE_W: if (expire) state_next = ST_WAIT_W;
        ST_WAIT_W:  if (expire) state_next = ST_VAC_W;
        ST_VAC_W: begin
          if (expire) begin
            cnt_next   = cnt_inc;
            state_next = (cnt_inc == target_q) ? ST_DONE : ST_PULSE_P;
          end
        end
        ST_DONE:  state_next = ST_IDLE;
        ST_FAULT: state_next = ST_FAULT;
        default:  state_next = ST_IDLE;
      endcase
`ifdef ALD_INTERLOCK_EN
      if ((state == ST_PULSE_P || state == ST_PULSE_W) && !pressure_ok) state_next = ST_FAULT;
`endif
    end
  end

  // Outputs are decoded from the next state so they switch with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cycle_count <= '0;
      start_q     <= 1'b0;
      sv_prec     <= 1'b0;
      sv_water    <= 1'b0;
      vv1         <= 1'b0;
      vv2         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      cycle_count <= cnt_next;
      start_q     <= start;
      sv_prec     <= (state_next == ST_PULSE_P);
      sv_water    <= (state_next == ST_PULSE_W);
      vv1         <= (state_next == ST_PREP) || (state_next == ST_VAC_P);
      vv2         <= (state_next == ST_PREP) || (state_next == ST_VAC_W);
      busy        <= (state_next != ST_IDLE);
      done        <= (state_next == ST_DONE);
    end
  end

  assign phase = state;

`ifdef ALD_INTERLOCK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault <= 1'b0;
    else      fault <= (state_next == ST_FAULT);
  end
`else
  logic unused_pressure;
  assign unused_pressure = pressure_ok;
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_ald_cycle_sequencer.sv
// Scoreboard bench for ald_cycle_sequencer: expected phase-change events are
// queued by the stimulus and checked by a monitor on every phase change.
module tb_ald_cycle_sequencer;
  import ald_pkg::*;

  logic        clk = 1'b0;
  logic        rst, tick, start, stop, temp_ok, pressure_ok, cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        sv_prec, sv_water, vv1, vv2, busy, done, fault;
  logic [3:0]  phase;
  logic [15:0] cycle_count;

  typedef struct {
    state_t      ph;
    logic [3:0]  valves;
    logic        busy;
    logic        done;
    logic        fault;
    logic [15:0] cnt;
    int          len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cycles = 0;
  int   pulse_cycles = 0;
  int   tick_period = 1;

  ald_cycle_sequencer #(.DUR_W(32), .CYC_W(16)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .temp_ok(temp_ok), .pressure_ok(pressure_ok), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .sv_prec(sv_prec),
    .sv_water(sv_water), .vv1(vv1), .vv2(vv2), .busy(busy), .done(done),
    .fault(fault), .phase(phase), .cycle_count(cycle_count)
  );

  initial forever #10 clk = ~clk;

  // Tick strobe: one clk high every tick_period clks (0 disables it).
  initial begin
    int n = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_period == 0) tick = 1'b0;
      else begin
        tick = ((n % tick_period) == 0);
        n++;
      end
    end
  end

  initial begin
    #(20 * 90000);
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Valve pattern {sv_prec, sv_water, vv1, vv2} required in each state.
  function automatic logic [3:0] valves_of(state_t ph);
    case (ph)
      ST_PREP:    return 4'b0011;
      ST_PULSE_P: return 4'b1000;
      ST_VAC_P:   return 4'b0010;
      ST_PULSE_W: return 4'b0100;
      ST_VAC_W:   return 4'b0001;
      default:    return 4'b0000;
    endcase
  endfunction

  task automatic push_phase(state_t ph, int cnt, int len);
    exp_t e;
    e.ph     = ph;
    e.valves = valves_of(ph);
    e.busy   = (ph != ST_IDLE);
    e.done   = (ph == ST_DONE);
    e.fault  = (ph == ST_FAULT);
    e.cnt    = 16'(cnt);
    e.len    = len;
    sb.push_back(e);
  endtask

  // Monitor: on every phase change pop one expected event and compare.
  initial begin
    int         since = 0;
    int         ev = 0;
    logic [3:0] last = 4'd0;
    exp_t       e;
    bit         ok;
    forever begin
      @(negedge clk);
      since++;
      if (done === 1'b1) done_cycles++;
      if (sv_prec === 1'b1 || sv_water === 1'b1) pulse_cycles++;
      if (phase !== last) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_event%0d phase=%0d after %0d clks, none expected", ev, phase, since);
        end else begin
          e = sb.pop_front();
          ok = (phase === e.ph) && ({sv_prec, sv_water, vv1, vv2} === e.valves) &&
               (busy === e.busy) && (done === e.done) && (fault === e.fault) &&
               (cycle_count === e.cnt) && (e.len < 0 || since == e.len);
          if (!ok) begin
            failures++;
            $display("[TB] FAIL event%0d got phase=%0d valves=%b busy=%b done=%b fault=%b cnt=%0d len=%0d need phase=%0d valves=%b busy=%b done=%b fault=%b cnt=%0d len=%0d",
                     ev, phase, {sv_prec, sv_water, vv1, vv2}, busy, done, fault, cycle_count, since,
                     e.ph, e.valves, e.busy, e.done, e.fault, e.cnt, e.len);
          end
        end
        ev++;
        last  = phase;
        since = 0;
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d need=%0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic write_cfg(int addr, int data);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(addr);
    cfg_wdata = 32'(data);
    step(1);
    cfg_we    = 1'b0;
  endtask

  task automatic wait_drain(int budget, string name);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    check_output({"drain_", name}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_phase(state_t ph, int budget, string name);
    int k = 0;
    while (phase !== ph && k < budget) begin
      step(1);
      k++;
    end
    check_output({"wait_", name}, phase, ph);
  endtask

  initial begin
    int d0, p0;
    rst = 1'b0; start = 1'b0; stop = 1'b0; temp_ok = 1'b1; pressure_ok = 1'b1;
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'd0;
    step(3);
    check_output("reset_outputs", {sv_prec, sv_water, vv1, vv2, busy, done, fault}, 0);
    check_output("reset_phase", phase, ST_IDLE);
    check_output("reset_count", cycle_count, 0);
    rst = 1'b1;
    step(2);

    // Default recipe, stop during WAIT_W of cycle 2.
    tick_period = 1;
    d0 = done_cycles;
    push_phase(ST_PREP, 0, -1);
    push_phase(ST_PULSE_P, 0, -1);
    push_phase(ST_WAIT_P, 0, 2000);
    push_phase(ST_VAC_P, 0, 3000);
    push_phase(ST_PULSE_W, 0, 4000);
    push_phase(ST_WAIT_W, 0, 6000);
    push_phase(ST_VAC_W, 0, 7000);
    push_phase(ST_PULSE_P, 1, 8000);
    push_phase(ST_WAIT_P, 1, 2000);
    push_phase(ST_VAC_P, 1, 3000);
    push_phase(ST_PULSE_W, 1, 4000);
    push_phase(ST_WAIT_W, 1, 6000);
    apply_stimulus();
    wait_drain(50000, "default");
    push_phase(ST_IDLE, 1, -1);
    step(50);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(5);
    wait_drain(10, "stop");
    check_output("stop_no_done", done_cycles - d0, 0);
    check_output("stop_count", cycle_count, 1);

    // All durations 2, target 3, tick every 4 clks.
    for (int i = 0; i < 6; i++) write_cfg(i, 2);
    write_cfg(6, 3);
    write_cfg(7, 99);
    tick_period = 4;
    d0 = done_cycles;
    push_phase(ST_PREP, 0, -1);
    push_phase(ST_PULSE_P, 0, -1);
    for (int c = 0; c < 3; c++) begin
      push_phase(ST_WAIT_P, c, 8);
      push_phase(ST_VAC_P, c, 8);
      push_phase(ST_PULSE_W, c, 8);
      push_phase(ST_WAIT_W, c, 8);
      push_phase(ST_VAC_W, c, 8);
      if (c < 2) push_phase(ST_PULSE_P, c + 1, 8);
      else       push_phase(ST_DONE, 3, 8);
    end
    push_phase(ST_IDLE, 3, 1);
    apply_stimulus();
    wait_drain(400, "run3");
    check_output("run3_done", done_cycles - d0, 1);
    check_output("run3_count", cycle_count, 3);

    // Target 0: PREP straight to DONE, no pulse valve.
    tick_period = 1;
    write_cfg(6, 0);
    d0 = done_cycles;
    p0 = pulse_cycles;
    push_phase(ST_PREP, 0, -1);
    push_phase(ST_DONE, 0, -1);
    push_phase(ST_IDLE, 0, 1);
    apply_stimulus();
    wait_drain(50, "target0");
    check_output("target0_done", done_cycles - d0, 1);
    check_output("target0_no_pulse", pulse_cycles - p0, 0);

    // WAIT_P duration 0; write and start edge while busy are ignored.
    write_cfg(1, 0);
    write_cfg(6, 1);
    for (int r = 0; r < 2; r++) begin
      push_phase(ST_PREP, 0, -1);
      push_phase(ST_PULSE_P, 0, -1);
      push_phase(ST_WAIT_P, 0, 2);
      push_phase(ST_VAC_P, 0, 1);
      push_phase(ST_PULSE_W, 0, 2);
      push_phase(ST_WAIT_W, 0, 2);
      push_phase(ST_VAC_W, 0, 2);
      push_phase(ST_DONE, 1, 2);
      push_phase(ST_IDLE, 1, 1);
      apply_stimulus();
      if (r == 0) begin
        step(1);
        write_cfg(0, 50);
        apply_stimulus();
      end
      wait_drain(100, "zero_dur");
    end

    // Asynchronous reset in VAC_P restores defaults.
    write_cfg(2, 1000);
    push_phase(ST_PREP, 0, -1);
    push_phase(ST_PULSE_P, 0, -1);
    push_phase(ST_WAIT_P, 0, 2);
    push_phase(ST_VAC_P, 0, 1);
    push_phase(ST_IDLE, 0, -1);
    apply_stimulus();
    wait_phase(ST_VAC_P, 100, "vac_p");
    step(5);
    rst = 1'b0;
    #1;
    check_output("rst_async_outputs", {sv_prec, sv_water, vv1, vv2, busy, done, fault}, 0);
    check_output("rst_async_phase", phase, ST_IDLE);
    check_output("rst_async_count", cycle_count, 0);
    step(3);
    rst = 1'b1;
    step(2);
    wait_drain(10, "rst");
    push_phase(ST_PREP, 0, -1);
    push_phase(ST_PULSE_P, 0, -1);
    push_phase(ST_WAIT_P, 0, 2000);
    push_phase(ST_VAC_P, 0, 3000);
    apply_stimulus();
    wait_drain(6000, "defaults");
    push_phase(ST_IDLE, 0, -1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    wait_drain(10, "defaults_stop");

`ifdef ALD_INTERLOCK_EN
    // Pressure drop in PULSE_W latches FAULT until stop.
    for (int i = 0; i < 6; i++) write_cfg(i, 2);
    write_cfg(6, 2);
    push_phase(ST_PREP, 0, -1);
    push_phase(ST_PULSE_P, 0, -1);
    push_phase(ST_WAIT_P, 0, 2);
    push_phase(ST_VAC_P, 0, 2);
    push_phase(ST_PULSE_W, 0, 2);
    push_phase(ST_FAULT, 0, -1);
    apply_stimulus();
    wait_phase(ST_PULSE_W, 100, "pulse_w");
    pressure_ok = 1'b0;
    wait_drain(20, "fault");
    apply_stimulus();
    step(10);
    check_output("fault_held_phase", phase, ST_FAULT);
    check_output("fault_held_flag", fault, 1);
    push_phase(ST_IDLE, 0, -1);
    pressure_ok = 1'b1;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    wait_drain(10, "fault_clear");
    check_output("fault_cleared", fault, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
